rs232_tx_serialiser: RTL and testbench

//  Downstream stage of the user_design output_rs232_tx stream.

---
 rtl/rs232_tx_serialiser_pkg.sv | 9 +
 rtl/rs232_tx_serialiser_if.sv | 8 +
 rtl/rs232_tx_serialiser_byte_fifo.sv | 42 ++++
 rtl/rs232_tx_serialiser.sv | 82 ++++++++
 tb/tb_rs232_tx_serialiser.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_tx_serialiser_pkg.sv
// rs232_tx_serialiser_pkg: shared FSM encoding, frame constants and baud divider helper
package rs232_tx_serialiser_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/rs232_tx_serialiser_if.sv
// rs232_tx_serialiser_if: 32-bit stb/ack stream feeding the serialiser
interface rs232_tx_serialiser_if;
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;
  modport master (output in_data, output in_stb, input in_ack);
  modport slave (input in_data, input in_stb, output in_ack);
endinterface

// File: rtl/rs232_tx_serialiser_byte_fifo.sv
// byte_fifo: circular buffer with occupancy count, async active-low reset
module byte_fifo
  import rs232_tx_serialiser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/rs232_tx_serialiser.sv
// rs232_tx_serialiser: buffers stream bytes and sends them as 8N1 frames, LSB first
module rs232_tx_serialiser
  import rs232_tx_serialiser_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rs232_tx_serialiser_if.slave  bus,
  output logic                  tx,
  output logic                  busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(DATA_BITS);
  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [IW-1:0] bit_q;
  logic [7:0]    shift_q, dout;
  logic          tx_q, busy_q, ack_q;
  logic          push, pop, full, empty, bit_end;
  logic [CW-1:0] count, count_d;
  logic          unused_hi;
  assign unused_hi  = ^bus.in_data[31:8];
  assign bus.in_ack = ack_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign push       = bus.in_stb && ack_q && !full;
  assign bit_end    = baud_q == BW'(CLKS_PER_BIT - 1);
  // a pop at the end of STOP chains straight into the next START
  assign pop        = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign count_d    = count + CW'(push) - CW'(pop);
  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // tx follows the state one cycle later, so every bit keeps its full width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q  <= count_d < CW'(FIFO_DEPTH);
      busy_q <= !empty || state_q != IDLE;
      tx_q   <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
      if (pop) begin
        shift_q <= dout;
        state_q <= START;
      end else if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            bit_q   <= '0;
          end
          DATA: begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + IW'(1);
            if (bit_q == IW'(DATA_BITS - 1)) state_q <= STOP;
          end
          STOP: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rs232_tx_serialiser.sv
// tb_rs232_tx_serialiser: directed, table-driven and random checks against a UART line decoder
module tb_rs232_tx_serialiser;
  localparam int FR = 160;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy;
  rs232_tx_serialiser_if bus();
  rs232_tx_serialiser #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .tx   (tx),
    .busy (busy)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, last_acc = 0, n_acc = 0, frames = 0;
  logic [7:0] exp_q[$], rx_q[$];
  int starts_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic lev(input int p, input logic [7:0] b);
    if (p < 16) return 1'b0;
    if (p < 144) return b[(p - 16) / 16];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.in_stb && bus.in_ack) begin
      exp_q.push_back(bus.in_data[7:0]);
      last_acc <= cyc + 1;
      n_acc <= n_acc + 1;
    end
  end

  // line decoder: checks every clock of each frame against the expected 8N1 waveform
  int p = -1;
  logic [7:0] cur_exp, rx;
  logic bad;
  always @(negedge clk) begin
    if (!rst) p = -1;
    else begin
      if (p < 0 && tx === 1'b0) begin
        p = 0;
        bad = 1'b0;
        rx = 8'h00;
        frames++;
        starts_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur_exp = 8'h00;
        end else cur_exp = exp_q.pop_front();
      end
      if (p >= 0) begin
        if (tx !== lev(p, cur_exp)) bad = 1'b1;
        if (p >= 16 && p < 144 && p % 16 == 8) rx[(p - 16) / 16] = tx;
        if (p == FR - 1) begin
          chk("frame_byte", {23'd0, bad, rx}, {24'd0, cur_exp});
          rx_q.push_back(rx);
          p = -1;
        end else p++;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int t = 0;
    bus.in_data = w;
    bus.in_stb = 1'b1;
    while (!bus.in_ack && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_stb = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int n);
    int t = 0;
    while (starts_q.size() <= n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("start_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy !== 1'b0 || p >= 0 || exp_q.size() != 0) && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20000) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ack", bus.in_ack, 0);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("ack_before_edge", bus.in_ack, 0);
    @(posedge clk);
    #1;
    chk("ack_after_release", bus.in_ack, 1);
  endtask

  typedef struct {logic [31:0] w; logic [7:0] b;} vec_t;
  vec_t vec[5];
  int n0, r0, s, acc, quiet_bad, f0, a0;
  logic [31:0] w;
  logic take, done;

  initial begin
    #900000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h12345655, 8'h55};
    vec[1] = '{32'hFFFFFF00, 8'h00};
    vec[2] = '{32'h000000FF, 8'hFF};
    vec[3] = '{32'h80000001, 8'h01};
    vec[4] = '{32'hABCDEF96, 8'h96};
    bus.in_data = '0;
    bus.in_stb = 1'b0;
    #2;
    do_reset();
    chk("idle_tx", tx, 1);

    n0 = starts_q.size();
    send(32'h12345655);
    acc = last_acc;
    wait_cyc(acc + 1);
    chk("busy_rise", busy, 1);
    wait_start(n0);
    s = starts_q[n0];
    chk("start_latency", s - acc, 2);
    wait_cyc(s + FR - 1);
    chk("busy_in_stop", busy, 1);
    chk("tx_stop", tx, 1);
    wait_cyc(s + FR);
    chk("busy_drop", busy, 0);
    wait_idle();
    chk("single_byte", rx_q[rx_q.size() - 1], 8'h55);

    for (int i = 0; i < 5; i++) begin
      r0 = rx_q.size();
      send(vec[i].w);
      wait_idle();
      chk("table_byte", rx_q[r0], vec[i].b);
    end

    n0 = starts_q.size();
    r0 = rx_q.size();
    send(32'h41);
    send(32'h42);
    send(32'h43);
    wait_idle();
    chk("burst_gap1", starts_q[n0 + 1] - starts_q[n0], FR);
    chk("burst_gap2", starts_q[n0 + 2] - starts_q[n0 + 1], FR);
    chk("burst_B", rx_q[r0 + 1], 8'h42);
    chk("burst_C", rx_q[r0 + 2], 8'h43);

    n0 = starts_q.size();
    r0 = rx_q.size();
    send(32'hA5);
    for (int i = 0; i < 16; i++) send(i);
    chk("ack_full", bus.in_ack, 0);
    send(32'h10);
    acc = last_acc;
    wait_idle();
    chk("refill_timing", acc, starts_q[n0 + 1]);
    chk("fill_count", rx_q.size() - r0, 18);
    chk("fill_last", rx_q[r0 + 17], 8'h10);
    chk("fill_gap", starts_q[n0 + 17] - starts_q[n0 + 16], FR);

    n0 = starts_q.size();
    send(32'h5A);
    for (int i = 1; i <= 4; i++) send(i);
    wait_start(n0);
    s = starts_q[n0];
    wait_cyc(s + 56);
    chk("mid_bit2", tx, 0);
    wait_cyc(s + 72);
    chk("mid_bit3", tx, 1);
    f0 = frames;
    do_reset();
    quiet_bad = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    chk("quiet_after_reset", quiet_bad, 0);
    chk("no_frames_after_reset", frames - f0, 0);
    r0 = rx_q.size();
    send(32'h3C);
    wait_idle();
    chk("post_reset_byte", rx_q[r0], 8'h3C);

    f0 = frames;
    a0 = n_acc;
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      bus.in_data = w;
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
        bus.in_stb = $urandom_range(0, 3) != 0;
        take = bus.in_stb && bus.in_ack;
        @(posedge clk);
        #1;
        done = take;
      end
      bus.in_stb = 1'b0;
      if (!done) chk("rand_send_timeout", 1, 0);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 300)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("rand_accepts", n_acc - a0, 60);
    chk("rand_frames", frames - f0, 60);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
